// File: rtl/ssd_tick_counter.sv
// Tick-driven up/down display counter with enable, clear, load and wrap/saturate limits.
// Latency: count, tick and wrap are registered and change one edge after the terminal prescaler cycle.
// Backpressure: none; en=0 freezes the prescaler and the count. Optional BCD_MODE_EN selects packed-BCD counting.
module ssd_tick_counter #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int TICK_HZ  = 100,
   parameter int WIDTH    = 16,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_down,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             wrap
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] TERM = PW'(DIV - 1);

`ifdef BCD_MODE_EN
   localparam int ND = WIDTH / 4;

   function automatic logic [WIDTH-1:0] all_nines();
      logic [WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < ND; i++) v[4*i +: 4] = 4'd9;
      return v;
   endfunction

   function automatic logic [WIDTH-1:0] cnt_inc(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      logic             carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < ND; i++) begin
         if (carry) begin
            if (v[4*i +: 4] >= 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] cnt_dec(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      logic             borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < ND; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Digits above 9 are not representable on the display, so clamp them on entry.
   function automatic logic [WIDTH-1:0] load_fix(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = v;
      for (int i = 0; i < ND; i++)
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      return r;
   endfunction
`else
   function automatic logic [WIDTH-1:0] all_nines();
      return '1;
   endfunction

   function automatic logic [WIDTH-1:0] cnt_inc(input logic [WIDTH-1:0] v);
      return v + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] cnt_dec(input logic [WIDTH-1:0] v);
      return v - WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] load_fix(input logic [WIDTH-1:0] v);
      return v;
   endfunction
`endif

   localparam logic [WIDTH-1:0] MAX_VAL = all_nines();

   logic [PW-1:0]    presc;
   logic [WIDTH-1:0] step_val;
   logic             step_lim;

   always_comb begin
      step_val = count;
      step_lim = 1'b0;
      if (up_down) begin
         step_lim = (count == MAX_VAL);
         step_val = cnt_inc(count);
      end else begin
         step_lim = (count == '0);
         step_val = cnt_dec(count);
      end
      if (step_lim && (SATURATE != 0)) step_val = count;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         presc <= '0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else if (clear) begin
         count <= '0;
         presc <= '0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else if (load) begin
         count <= load_fix(load_value);
         presc <= '0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         if (en) begin
            if (presc == TERM) begin
               presc <= '0;
               count <= step_val;
               tick  <= 1'b1;
               wrap  <= step_lim;
            end else begin
               presc <= presc + PW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ssd_tick_counter.sv
// Randomised bench for ssd_tick_counter: two instances (wrap and saturate) share stimulus;
// a value-level reference model feeds an expectation queue drained by an independent monitor.
module tb_ssd_tick_counter;

   localparam int CLK_HZ  = 10;
   localparam int TICK_HZ = 1;
   localparam int DIV     = CLK_HZ / TICK_HZ;
   localparam int WIDTH   = 8;

   logic             clk = 1'b0;
   logic             rst, en, up_down, clear, load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count_w, count_s;
   logic             tick_w, tick_s, wrap_w, wrap_s;

   always #5 clk = ~clk;

   ssd_tick_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .WIDTH(WIDTH), .SATURATE(0)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .up_down(up_down), .clear(clear), .load(load),
      .load_value(load_value), .count(count_w), .tick(tick_w), .wrap(wrap_w));

   ssd_tick_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .WIDTH(WIDTH), .SATURATE(1)) u_sat (
      .clk(clk), .rst(rst), .en(en), .up_down(up_down), .clear(clear), .load(load),
      .load_value(load_value), .count(count_s), .tick(tick_s), .wrap(wrap_s));

   typedef struct packed {
      logic [WIDTH-1:0] cnt_w;
      logic             tick_w;
      logic             wrap_w;
      logic [WIDTH-1:0] cnt_s;
      logic             tick_s;
      logic             wrap_s;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   stim_done = 1'b0;

   // Model state: prescaler phase and the count as a plain number per instance.
   int m_presc;
   int m_val[2];

`ifdef BCD_MODE_EN
   localparam int ND = WIDTH / 4;
   function automatic int max_val();
      int p = 1;
      for (int i = 0; i < ND; i++) p = p * 10;
      return p - 1;
   endfunction
   function automatic int to_val(input logic [WIDTH-1:0] b);
      int v = 0;
      int p = 1;
      for (int i = 0; i < ND; i++) begin
         int d = int'(b[4*i +: 4]);
         if (d > 9) d = 9;
         v = v + d * p;
         p = p * 10;
      end
      return v;
   endfunction
   function automatic logic [WIDTH-1:0] to_bits(input int v);
      logic [WIDTH-1:0] b = '0;
      int t = v;
      for (int i = 0; i < ND; i++) begin
         b[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return b;
   endfunction
`else
   function automatic int max_val();
      return (1 << WIDTH) - 1;
   endfunction
   function automatic int to_val(input logic [WIDTH-1:0] b);
      return int'(b);
   endfunction
   function automatic logic [WIDTH-1:0] to_bits(input int v);
      return WIDTH'(v);
   endfunction
`endif

   task automatic model(input logic r, e, u, c, l, input logic [WIDTH-1:0] lv);
      exp_t x;
      logic [1:0] tk = 2'b00;
      logic [1:0] wr = 2'b00;
      int mx = max_val();
      if (r || c) begin
         m_presc = 0;
         m_val[0] = 0;
         m_val[1] = 0;
      end else if (l) begin
         m_presc = 0;
         m_val[0] = to_val(lv);
         m_val[1] = to_val(lv);
      end else if (e) begin
         if (m_presc == DIV - 1) begin
            m_presc = 0;
            for (int s = 0; s < 2; s++) begin
               tk[s] = 1'b1;
               if (u) begin
                  if (m_val[s] == mx) begin
                     wr[s] = 1'b1;
                     m_val[s] = (s == 1) ? mx : 0;
                  end else m_val[s] = m_val[s] + 1;
               end else begin
                  if (m_val[s] == 0) begin
                     wr[s] = 1'b1;
                     m_val[s] = (s == 1) ? 0 : mx;
                  end else m_val[s] = m_val[s] - 1;
               end
            end
         end else m_presc = m_presc + 1;
      end
      x.cnt_w  = to_bits(m_val[0]);
      x.tick_w = tk[0];
      x.wrap_w = wr[0];
      x.cnt_s  = to_bits(m_val[1]);
      x.tick_s = tk[1];
      x.wrap_s = wr[1];
      exp_q.push_back(x);
   endtask

   task automatic cyc(input logic r, e, u, c, l, input logic [WIDTH-1:0] lv);
      @(negedge clk);
      rst = r; en = e; up_down = u; clear = c; load = l; load_value = lv;
      model(r, e, u, c, l, lv);
   endtask

   task automatic run(input logic e, u, input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, e, u, 1'b0, 1'b0, '0);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t x;
         x = exp_q.pop_front();
         checks++;
         if (count_w !== x.cnt_w || tick_w !== x.tick_w || wrap_w !== x.wrap_w) begin
            failures++;
            $display("FAIL wrap_inst t=%0t got count=%h tick=%b wrap=%b want count=%h tick=%b wrap=%b",
                     $time, count_w, tick_w, wrap_w, x.cnt_w, x.tick_w, x.wrap_w);
         end
         checks++;
         if (count_s !== x.cnt_s || tick_s !== x.tick_s || wrap_s !== x.wrap_s) begin
            failures++;
            $display("FAIL sat_inst t=%0t got count=%h tick=%b wrap=%b want count=%h tick=%b wrap=%b",
                     $time, count_s, tick_s, wrap_s, x.cnt_s, x.tick_s, x.wrap_s);
         end
      end
   end

   logic [WIDTH-1:0] lv_tab [8];
   logic             ud;

   initial begin
      rst = 1'b1; en = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0;
      lv_tab[0] = 8'h00; lv_tab[1] = 8'h01; lv_tab[2] = 8'hFE; lv_tab[3] = 8'hFF;
      lv_tab[4] = 8'h98; lv_tab[5] = 8'h99; lv_tab[6] = 8'h1A; lv_tab[7] = 8'h10;

      // Reset, then count up through two ticks.
      repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      run(1'b1, 1'b1, 25);
      // Upper limit from a load near the top.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFE);
      run(1'b1, 1'b1, 25);
      // Lower limit counting down.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      run(1'b1, 1'b0, 15);
      // Enable hold mid-period.
      run(1'b1, 1'b1, 5);
      run(1'b0, 1'b1, 25);
      run(1'b1, 1'b1, 15);
      // Clear and load together on the terminal cycle.
      for (int k = 0; k < DIV && m_presc != DIV - 1; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
      run(1'b1, 1'b1, 12);
      // Load with en low, digit clamp value, and a down step across a digit boundary.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1A);
      run(1'b1, 1'b1, 11);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h99);
      run(1'b1, 1'b1, 11);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
      run(1'b1, 1'b0, 11);
      // Reset mid-count wins over everything else.
      run(1'b1, 1'b1, 4);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
      run(1'b1, 1'b1, 12);

      ud = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         logic r, e, c, l;
         logic [WIDTH-1:0] lv;
         if ($urandom_range(0, 19) == 0) ud = ~ud;
         r  = ($urandom_range(0, 299) == 0);
         e  = ($urandom_range(0, 9) != 0);
         c  = ($urandom_range(0, 79) == 0);
         l  = ($urandom_range(0, 39) == 0);
         lv = ($urandom_range(0, 1) == 0) ? lv_tab[$urandom_range(0, 7)] : WIDTH'($urandom);
         cyc(r, e, ud, c, l, lv);
      end

      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
